// File: rtl/amc_pixel_writer.sv
// Pixel write master: one Draw/Write_Finish handshake becomes one 16-bit Avalon-MM write.
// Define POSTED_WRITE_EN to decouple the handshake from the bus with a FIFO_DEPTH-entry posted-write FIFO.
module amc_pixel_writer #(
    parameter int CNT_W = 16
`ifdef POSTED_WRITE_EN
    ,
    parameter int FIFO_DEPTH = 4
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             Draw,
    input  logic [31:0]      Pixel_Address,
    input  logic [15:0]      Color,
    output logic             Write_Finish,
    output logic             Busy,
    output logic [CNT_W-1:0] Pixel_Count,
    output logic [31:0]      master_address,
    output logic             master_write,
    output logic [15:0]      master_writedata,
    output logic [1:0]       master_byteenable,
    input  logic             master_waitrequest
);

    logic accept;
    logic addr_lsb_unused;

    // Halfword-aligned pixel buffer: address bit 0 never reaches the bus.
    assign addr_lsb_unused   = Pixel_Address[0];
    assign master_byteenable = 2'b11;
    assign accept            = master_write && !master_waitrequest;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            Pixel_Count <= '0;
        end else if (accept) begin
            Pixel_Count <= Pixel_Count + CNT_W'(1);
        end
    end

`ifdef POSTED_WRITE_EN

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic {FE_IDLE, FE_ACK} fe_state_t;

    fe_state_t        fe_state;
    logic [30:0]      fifo_addr [FIFO_DEPTH];
    logic [15:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic             push;
    logic             pop;
    logic [30:0]      head_addr;
    logic [15:0]      head_data;

    // Next head entry; bypass the storage when the pushed pixel becomes the head this edge.
    always_comb begin
        push       = (fe_state == FE_IDLE) && Draw && (fill != FILL_W'(FIFO_DEPTH));
        pop        = accept;
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        fill_nxt   = fill + FILL_W'(push) - FILL_W'(pop);
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_addr = Pixel_Address[31:1];
            head_data = Color;
        end else begin
            head_addr = fifo_addr[rd_ptr_nxt];
            head_data = fifo_data[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= Pixel_Address[31:1];
            fifo_data[wr_ptr] <= Color;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fe_state         <= FE_IDLE;
            Write_Finish     <= 1'b0;
            Busy             <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fill             <= '0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            fe_state     <= push ? FE_ACK : FE_IDLE;
            Write_Finish <= push;
            Busy         <= (fill_nxt != '0) || push;
            wr_ptr       <= wr_ptr + PTR_W'(push);
            rd_ptr       <= rd_ptr_nxt;
            fill         <= fill_nxt;
            master_write <= (fill_nxt != '0);
            if (fill_nxt != '0) begin
                master_address   <= {head_addr, 1'b0};
                master_writedata <= head_data;
            end
        end
    end

`else

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FINISH} state_t;

    state_t state;

    // IDLE is only re-entered after FINISH, so a held Draw is sampled once the requester has advanced.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            Write_Finish     <= 1'b0;
            Busy             <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Draw) begin
                        master_address   <= {Pixel_Address[31:1], 1'b0};
                        master_writedata <= Color;
                        master_write     <= 1'b1;
                        Busy             <= 1'b1;
                        state            <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        Write_Finish <= 1'b1;
                        state        <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    Write_Finish <= 1'b0;
                    Busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: doc/amc_pixel_writer.md
Name: amc_pixel_writer

Overview:
Pixel write master serving the line-drawing circuit's Draw / Write_Finish handshake. It takes one pixel per handshake (address plus 16-bit colour) and issues it as a single Avalon-MM master write to the pixel buffer. It pulses Write_Finish so the requester can step to the next pixel. It sits between the line drawer and the SDRAM/SRAM pixel-buffer interconnect.

Parameters:
CNT_W, 16, width of the Pixel_Count accepted-write counter (wraps)
FIFO_DEPTH, 4, posted-write FIFO entries; power of 2, >=2; used only when POSTED_WRITE_EN is defined

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  reset, asynchronous, active-low
Draw  in  1  pixel request; may be held high across consecutive pixels
Pixel_Address  in  32  byte address of pixel; valid while Draw=1
Color  in  16  RGB565 pixel value; valid while Draw=1
Write_Finish  out  1  registered one-cycle pulse: current pixel taken, requester may advance
Busy  out  1  high while any write is pending or in flight
Pixel_Count  out  CNT_W  count of writes accepted by the Avalon fabric
master_address  out  32  Avalon address
master_write  out  1  Avalon write strobe
master_writedata  out  16  Avalon write data
master_byteenable  out  2  constant 2'b11
master_waitrequest  in  1  Avalon stall

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-low reset (resetn).
- Reset values: master_write=0, Write_Finish=0, Busy=0, Pixel_Count=0, master_address=0, master_writedata=0, FSM=IDLE.
- Async assertion takes effect immediately, including mid-transfer. An aborted write is dropped and not retried.
- All outputs are registered.
- Address handling: master_address = {Pixel_Address[31:1], 1'b0}. Bit 0 is forced to 0 (halfword alignment).
- Acceptance: a write counts as accepted on any cycle with master_write=1 and master_waitrequest=0. Pixel_Count increments by 1 on each acceptance and wraps modulo 2^CNT_W.
- Non-posted FSM (default), three states:
  - IDLE: if Draw=1, latch address/colour, set master_write=1, go to WRITE. Otherwise stay.
  - WRITE: hold master_write, address and data stable. On acceptance, drop master_write next edge and go to FINISH.
  - FINISH: Write_Finish=1 for exactly this cycle. Draw is ignored. Go to IDLE.
- Sampling rule: the requester updates Pixel_Address in the cycle after Write_Finish. IDLE samples that cycle, so a held-high Draw never writes the same pixel twice.
- Latency: Draw sampled at edge 0 -> master_write high in cycle 1. With no wait, Write_Finish in cycle 2 and the next Draw is sampled at edge 3. Minimum throughput is 3 cycles/pixel.
- Each waitrequest cycle adds one cycle of latency.
- Busy = (state != IDLE).
- Draw falling while in WRITE: the transfer still completes and Write_Finish still pulses.

Optional Feature:
POSTED_WRITE_EN:
- Defined: requests go into a FIFO of FIFO_DEPTH {address,colour} entries.
- Front-end FSM, two states:
  - IDLE: if Draw=1 and FIFO not full, push and go to ACK.
  - ACK: Write_Finish=1 for one cycle, then go to IDLE.
  - Result: 2 cycles/pixel, independent of waitrequest.
- FIFO full: no push, Write_Finish withheld until a slot frees.
- Back end: master_write = FIFO not empty; address/data taken from the head entry; pop on acceptance.
- Simultaneous push and pop: occupancy unchanged, both take effect.
- Ordering is strictly FIFO.
- Busy = FIFO not empty or front end in ACK.
- Not defined: non-posted behaviour above; no FIFO storage is synthesised.

Test Plan:
- Single write, waitrequest=0, Draw=1 with address 0x0800_0403, colour 0xF800 -> cycle 1: master_write=1, master_address=0x0800_0402, data=0xF800, byteenable=2'b11; cycle 2: Write_Finish=1 for one cycle; Pixel_Count=1; Busy low by cycle 3.
- Stall: waitrequest high for 3 cycles after master_write rises -> master_write high for 4 cycles with address/data stable; Write_Finish exactly 1 cycle after acceptance.
- Back-to-back: Draw held high for 5 pixels, address 0x100,0x102,...,0x108, each changing the cycle after Write_Finish -> exactly 5 Avalon writes in order, 5 Write_Finish pulses, no duplicates; Pixel_Count=5.
- Reset mid-WRITE: resetn low during a stall -> master_write, Write_Finish, Busy and Pixel_Count are 0 immediately; after release with Draw=0, no write is issued.
- Wrap: CNT_W=4, 17 accepted writes -> Pixel_Count=1.
- POSTED_WRITE_EN, FIFO_DEPTH=4: waitrequest stuck high, 6 pixel requests -> 4 Write_Finish pulses, then Write_Finish withheld; release waitrequest -> all 6 writes drain in order, 2 further pulses; final Pixel_Count=6, Busy=0.
